bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU data bus (Bus_addr/Bus_wdata/Bus_wen/Bus_rdata) toward the Bridge.
- Shares the bus between master 0 (CPU data port) and master 1 (DMA/debug loader).
- Round-robin arbitration with a req/ack handshake.
- Models a slave with a fixed number of wait states, so masters see a multi-cycle transfer.

Parameters:
- WAIT_CYCLES, 1, extra cycles the slave needs before bus_rdata is valid; legal range 0..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- m0_req  input  1  master 0 request; held high until m0_ack.
- m0_wen  input  1  master 0 write (1) / read (0).
- m0_addr  input  AW  master 0 address.
- m0_wdata  input  DW  master 0 write data.
- m0_ack  output  1  one-cycle completion pulse to master 0.
- m0_rdata  output  DW  read data; valid while m0_ack=1.
- m1_req, m1_wen, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_*, for master 1.
- bus_addr  output  AW  slave address.
- bus_wen  output  1  slave write strobe.
- bus_wdata  output  DW  slave write data.
- bus_rdata  input  DW  slave read data.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  1  master owning the current transfer; 0 when idle.

Behaviour:
- Reset (synchronous): state=IDLE, last_grant=1 (master 0 wins the first tie). All outputs 0: acks, rdata, bus_addr, bus_wen, bus_wdata, busy, grant_id.
- States: IDLE, XFER, RESP.
- IDLE, arbitration happens here only:
  - If exactly one req is high, grant that master.
  - If both are high, grant the master that is not last_grant.
  - On grant, latch id, addr, wen and wdata into internal registers. Set last_grant=id, cnt=WAIT_CYCLES, next state=XFER.
  - With no req, stay in IDLE.
- XFER:
  - bus_addr/bus_wdata are driven from the latched registers for the whole state.
  - bus_wen is high only in the first XFER cycle (single write pulse), and only if the latched wen=1.
  - While cnt≠0: decrement cnt and stay in XFER.
  - When cnt==0: capture bus_rdata into the rdata register (reads only; writes capture 0), next state=RESP.
  - Duration is WAIT_CYCLES+1 cycles.
- RESP:
  - Assert ack of the granted master for exactly one cycle. Its rdata shows the captured value; the other master's rdata stays 0.
  - Bus outputs return to 0. Next state=IDLE.
- Latency: from the edge where req is sampled in IDLE to the ack cycle is WAIT_CYCLES+2 cycles. The bus is idle for one cycle between back-to-back transfers.
- Requester rule: drop req in the cycle after ack. A req still high in IDLE after ack is treated as a new request.
- Changing addr/wdata/wen after the grant has no effect; values are latched at grant.
- The non-granted master's req is held pending and never lost. It is granted at the next IDLE, taking round-robin priority if both request.
- Outside RESP, rdata outputs hold 0.
- Reset mid-XFER/RESP: abort the transfer with no ack. bus_wen=0 from the reset cycle onward, state=IDLE, last_grant=1.
- A req asserted during reset is not granted before the first non-reset IDLE cycle.

Optional Feature:
- Macro: BUS_ARBITER_LOCK_EN.
- Enabled:
  - Adds inputs m0_lock and m1_lock (1 bit each).
  - If the granted master has lock=1 in its RESP cycle, it becomes the locked owner.
  - In the next IDLE, the locked owner is granted if its req is high, regardless of round-robin; otherwise the lock clears and normal arbitration applies.
  - Reset clears the lock.
- Disabled: lock ports are absent; pure round-robin as above.

Test Plan:
- Reset check: hold rst_i 2 cycles -> every output 0, busy=0; with only m1_req=1 after reset, m1 is granted at the first IDLE cycle.
- Single read, WAIT_CYCLES=2: m0_req=1, m0_addr=0x1000, bus_rdata=0xDEADBEEF -> bus_addr=0x1000 for 3 cycles; m0_ack pulses 4 cycles after sampling with m0_rdata=0xDEADBEEF; bus_wen stays 0.
- Single write: m1 write addr=0x2004, wdata=0x55AA -> bus_wen high for exactly 1 cycle with bus_wdata=0x55AA; m1_ack one cycle after XFER ends; m1_rdata=0.
- Contention: both req held continuously, each dropping for 1 cycle after its ack -> grants alternate 0,1,0,1; no master is starved; acks never overlap.
- Reset mid-XFER: assert rst_i in the 2nd XFER cycle of an m0 read -> no m0_ack; busy=0 next cycle; the following request completes normally.
- Lock (BUS_ARBITER_LOCK_EN): m1_lock=1, both requesting -> m1 is granted 3 consecutive times; dropping m1_lock lets m0 be granted next.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Per-master request/ack channel between a bus master and the arbiter.
// The lock signal exists only when BUS_ARBITER_LOCK_EN is defined.
interface bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
`ifdef BUS_ARBITER_LOCK_EN
    logic          lock;

    modport master (output req, wen, addr, wdata, lock, input ack, rdata);
    modport slave  (input req, wen, addr, wdata, lock, output ack, rdata);
`else
    modport master (output req, wen, addr, wdata, input ack, rdata);
    modport slave  (input req, wen, addr, wdata, output ack, rdata);
`endif
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter toward a slave with WAIT_CYCLES wait states; optional lock via BUS_ARBITER_LOCK_EN.
// Latency: req sampled in IDLE to ack is WAIT_CYCLES+2 cycles; one idle bus cycle between transfers.
// Backpressure: the losing master's req stays pending and is served at the next IDLE.
module bus_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    bus_arbiter_if.slave  m0,
    bus_arbiter_if.slave  m1,
    output logic [AW-1:0] bus_addr,
    output logic          bus_wen,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic          busy,
    output logic          grant_id
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t        state_q, state_d;
    logic          last_grant_q;
    logic          id_q;
    logic          wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [3:0]    cnt_q;
    logic          gnt_vld;
    logic          gnt_id;
`ifdef BUS_ARBITER_LOCK_EN
    logic          lock_vld_q;
    logic          lock_id_q;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_vld   = 1'b0;
        gnt_id    = 1'b0;
        busy      = 1'b0;
        grant_id  = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wen   = 1'b0;
        m0.ack    = 1'b0;
        m1.ack    = 1'b0;
        m0.rdata  = '0;
        m1.rdata  = '0;

        unique case (state_q)
            IDLE: begin
                gnt_vld = m0.req | m1.req;
                gnt_id  = (m0.req & m1.req) ? ~last_grant_q : m1.req;
`ifdef BUS_ARBITER_LOCK_EN
                if (lock_vld_q && (lock_id_q ? m1.req : m0.req)) begin
                    gnt_id = lock_id_q;
                end
`endif
                if (gnt_vld) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy     = (state_q != IDLE);
        grant_id = busy ? id_q : 1'b0;

        if (state_q == XFER) begin
            bus_addr  = addr_q;
            bus_wdata = wdata_q;
            // cnt still at its load value marks the first XFER cycle; reset suppresses the strobe at once
            bus_wen   = wen_q && (cnt_q == CNT_INIT) && !rst_i;
        end

        if (state_q == RESP && !rst_i) begin
            m0.ack = ~id_q;
            m1.ack = id_q;
            if (id_q) begin
                m1.rdata = rdata_q;
            end else begin
                m0.rdata = rdata_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= 4'd0;
`ifdef BUS_ARBITER_LOCK_EN
            lock_vld_q   <= 1'b0;
            lock_id_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            if (gnt_vld) begin
                id_q         <= gnt_id;
                last_grant_q <= gnt_id;
                wen_q        <= gnt_id ? m1.wen   : m0.wen;
                addr_q       <= gnt_id ? m1.addr  : m0.addr;
                wdata_q      <= gnt_id ? m1.wdata : m0.wdata;
                cnt_q        <= CNT_INIT;
            end else if (state_q == XFER && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (state_q == XFER && cnt_q == 4'd0) begin
                rdata_q <= wen_q ? '0 : bus_rdata;
            end

`ifdef BUS_ARBITER_LOCK_EN
            // ownership is decided by the lock level seen during the owner's RESP cycle
            if (state_q == RESP) begin
                lock_vld_q <= id_q ? m1.lock : m0.lock;
                lock_id_q  <= id_q;
            end else if (state_q == IDLE) begin
                lock_vld_q <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level model.
module tb_bus_arbiter;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_wen;
    logic        busy;
    logic        grant_id;

    bus_arbiter_if #(.AW(32), .DW(32)) m0_if ();
    bus_arbiter_if #(.AW(32), .DW(32)) m1_if ();

    bus_arbiter #(.WAIT_CYCLES(W), .AW(32), .DW(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .bus_addr  (bus_addr),
        .bus_wen   (bus_wen),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          exp_wen;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic        drv_req [2];
    logic        drv_wen [2];
    logic [31:0] drv_addr[2];
    logic [31:0] drv_wd  [2];
`ifdef BUS_ARBITER_LOCK_EN
    logic        drv_lock[2];
`endif

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] snap();
        return {27'b0, busy, grant_id, bus_wen, bus_addr, bus_wdata,
                m0_if.ack, m1_if.ack, m0_if.rdata, m1_if.rdata};
    endfunction

    task automatic apply();
        m0_if.req   = drv_req[0];
        m0_if.wen   = drv_wen[0];
        m0_if.addr  = drv_addr[0];
        m0_if.wdata = drv_wd[0];
        m1_if.req   = drv_req[1];
        m1_if.wen   = drv_wen[1];
        m1_if.addr  = drv_addr[1];
        m1_if.wdata = drv_wd[1];
`ifdef BUS_ARBITER_LOCK_EN
        m0_if.lock  = drv_lock[0];
        m1_if.lock  = drv_lock[1];
`endif
    endtask

    task automatic clear_drv();
        for (int m = 0; m < 2; m++) begin
            drv_req[m]  = 1'b0;
            drv_wen[m]  = 1'b0;
            drv_addr[m] = '0;
            drv_wd[m]   = '0;
`ifdef BUS_ARBITER_LOCK_EN
            drv_lock[m] = 1'b0;
`endif
        end
        bus_rdata = '0;
        apply();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_drv();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for the ack of master id; lat counts cycles from the current one.
    task automatic wait_ack(input bit id, output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = '1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ((id ? m1_if.ack : m0_if.ack) === 1'b1) begin
                lat = c;
                rd  = id ? m1_if.rdata : m0_if.rdata;
                break;
            end
            tick();
        end
        tick();
        drv_req[id] = 1'b0;
        apply();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        int          lat, wen_cyc, match_cyc, n, overlap, m1cnt;
        logic [31:0] rd, other_rd;
        logic [7:0]  ord;
        logic [159:0] exp;
        bit          a0, a1;
        int          age;
        bit          mid, mwen, mlast;
        logic [31:0] maddr, mwd, mrd;
        bit          eack[2];

        vecs[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0000_0000, 32'hDEAD_BEEF, W+2, 32'hDEAD_BEEF, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2004, 32'h0000_55AA, 32'h1234_5678, W+2, 32'h0, 1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0000_0000, 32'hCAFE_F00D, W+2, 32'hCAFE_F00D, 0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 32'hA5A5_A5A5, W+2, 32'h0, 1};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, W+2, 32'h0, 0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFF, W+2, 32'hFFFF_FFFF, 0};

        // Reset state, with m1 requesting throughout reset.
        rst = 1'b1;
        clear_drv();
        drv_req[1]  = 1'b1;
        drv_addr[1] = 32'h80;
        apply();
        tick();
        tick();
        @(negedge clk);
        chk("reset_outputs_zero", snap(), '0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("first_idle_not_busy", {busy, grant_id}, 2'b00);
        tick();
        @(negedge clk);
        chk("m1_granted_after_reset", {busy, grant_id, bus_addr}, {2'b11, 32'h80});
        tick();
        wait_ack(1'b1, lat, rd);
        chk("after_reset_m1_ack_lat", lat, W);
        tick();

        // Directed single transfers; master fields are scrambled right after the grant.
        for (int i = 0; i < 6; i++) begin
            clear_drv();
            drv_req[vecs[i].id]  = 1'b1;
            drv_wen[vecs[i].id]  = vecs[i].wen;
            drv_addr[vecs[i].id] = vecs[i].addr;
            drv_wd[vecs[i].id]   = vecs[i].wdata;
            bus_rdata            = vecs[i].rdata;
            apply();
            lat = -1; wen_cyc = 0; match_cyc = 0; rd = '1; other_rd = '1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if ((vecs[i].id ? m1_if.ack : m0_if.ack) === 1'b1) begin
                    lat      = c;
                    rd       = vecs[i].id ? m1_if.rdata : m0_if.rdata;
                    other_rd = vecs[i].id ? m0_if.rdata : m1_if.rdata;
                    break;
                end
                if (bus_wen) wen_cyc++;
                if (busy && grant_id == vecs[i].id && bus_addr == vecs[i].addr &&
                    bus_wdata == vecs[i].wdata) match_cyc++;
                tick();
                if (c == 0) begin
                    drv_addr[vecs[i].id] = ~vecs[i].addr;
                    drv_wd[vecs[i].id]   = ~vecs[i].wdata;
                    drv_wen[vecs[i].id]  = ~vecs[i].wen;
                    apply();
                end
            end
            tick();
            drv_req[vecs[i].id] = 1'b0;
            apply();
            tick();
            chk($sformatf("vec%0d_ack_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_other_rdata", i), other_rd, 32'h0);
            chk($sformatf("vec%0d_bus_cycles", i), match_cyc, W+1);
            chk($sformatf("vec%0d_wen_cycles", i), wen_cyc, vecs[i].exp_wen);
        end

        // Contention: both request, each drops req for the cycle after its ack.
        do_reset();
        drv_req[0] = 1'b1; drv_addr[0] = 32'h100;
        drv_req[1] = 1'b1; drv_addr[1] = 32'h200;
        apply();
        n = 0; overlap = 0; ord = '0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk);
            a0 = m0_if.ack;
            a1 = m1_if.ack;
            if (a0 && a1) overlap++;
            if (a0) begin ord = {ord[6:0], 1'b0}; n++; end
            if (a1) begin ord = {ord[6:0], 1'b1}; n++; end
            tick();
            drv_req[0] = !a0;
            drv_req[1] = !a1;
            apply();
        end
        chk("contention_ack_count", n, 4);
        chk("contention_order", ord[3:0], 4'b0101);
        chk("contention_no_overlap", overlap, 0);

        // Reset during the first XFER cycle of a write kills the strobe in that cycle.
        do_reset();
        drv_req[1] = 1'b1; drv_wen[1] = 1'b1; drv_addr[1] = 32'h44; drv_wd[1] = 32'h77;
        apply();
        tick();
        chk("write_strobe_before_reset", bus_wen, 1'b1);
        rst = 1'b1;
        #1;
        chk("write_strobe_in_reset_cycle", bus_wen, 1'b0);
        tick();
        rst = 1'b0;
        drv_req[1] = 1'b0;
        apply();
        tick();

        // Reset in the second XFER cycle of an m0 read: no ack, then a clean retry.
        do_reset();
        drv_req[0] = 1'b1; drv_addr[0] = 32'h1000;
        bus_rdata = 32'h1122_3344;
        apply();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midxfer_reset_no_ack", {m0_if.ack, m1_if.ack}, 2'b00);
        tick();
        rst = 1'b0;
        #2;
        chk("midxfer_reset_busy_low", {busy, grant_id, m0_if.ack}, 3'b000);
        wait_ack(1'b0, lat, rd);
        chk("midxfer_retry_latency", lat, W+2);
        chk("midxfer_retry_rdata", rd, 32'h1122_3344);
        tick();

`ifdef BUS_ARBITER_LOCK_EN
        // m1 holds its lock for two RESP cycles, then releases it.
        do_reset();
        drv_req[0] = 1'b1; drv_req[1] = 1'b1; drv_lock[1] = 1'b1;
        apply();
        n = 0; m1cnt = 0; ord = '0;
        for (int c = 0; c < 150 && n < 5; c++) begin
            @(negedge clk);
            if (m0_if.ack) begin ord = {ord[6:0], 1'b0}; n++; end
            if (m1_if.ack) begin ord = {ord[6:0], 1'b1}; n++; m1cnt++; end
            tick();
            drv_lock[1] = (m1cnt < 2);
            apply();
        end
        chk("lock_ack_count", n, 5);
        chk("lock_order", ord[4:0], 5'b01110);
        clear_drv();
        tick();
`endif

        // Randomized traffic against a transfer-position model.
        do_reset();
        age = 0; mlast = 1'b1; mid = 1'b0; mwen = 1'b0;
        maddr = '0; mwd = '0; mrd = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            exp = '0;
            if (age >= 1 && age <= W+1) begin
                exp = {27'b0, 1'b1, mid, (mwen && age == 1), maddr, mwd, 1'b0, 1'b0, 32'h0, 32'h0};
            end else if (age == W+2) begin
                exp = {27'b0, 1'b1, mid, 1'b0, 32'h0, 32'h0, !mid, mid,
                       (mid ? 32'h0 : mrd), (mid ? mrd : 32'h0)};
            end
            chk("random_cycle", snap(), exp);
            eack[0] = (age == W+2) && !mid;
            eack[1] = (age == W+2) && mid;
            if (age == 0) begin
                if (drv_req[0] || drv_req[1]) begin
                    mid   = (drv_req[0] && drv_req[1]) ? !mlast : drv_req[1];
                    mwen  = drv_wen[mid];
                    maddr = drv_addr[mid];
                    mwd   = drv_wd[mid];
                    mlast = mid;
                    age   = 1;
                end
            end else begin
                if (age == W+1) mrd = mwen ? 32'h0 : bus_rdata;
                age = (age == W+2) ? 0 : age + 1;
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                if (eack[m]) begin
                    drv_req[m] = 1'b0;
                end else if (!drv_req[m]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        drv_req[m]  = 1'b1;
                        drv_wen[m]  = 1'($urandom_range(0, 1));
                        drv_addr[m] = $urandom;
                        drv_wd[m]   = $urandom;
                    end
                end else begin
                    if ($urandom_range(0, 1) == 1) drv_addr[m] = $urandom;
                    if ($urandom_range(0, 1) == 1) drv_wd[m]   = $urandom;
                    if ($urandom_range(0, 1) == 1) drv_wen[m]  = 1'($urandom_range(0, 1));
                end
            end
            bus_rdata = $urandom;
            apply();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
